// File: rtl/keccak_msg_packer.sv
// Byte-stream to 32-bit big-endian word packer feeding a keccak core's message port.
// Optional KECCAK_MSG_PACKER_LEN_EN adds a msg_len byte counter output.
module keccak_msg_packer #(
    parameter int RESET_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        core_reset,
    output logic [31:0] core_in,
    output logic        core_in_ready,
    output logic        core_is_last,
    output logic [1:0]  core_byte_num,
    input  logic        core_buffer_full,
    input  logic        core_out_ready,
    output logic        busy,
`ifdef KECCAK_MSG_PACKER_LEN_EN
    output logic [31:0] msg_len,
`endif
    output logic        msg_done
);

    typedef enum logic [2:0] {IDLE, CLR, FILL, SEND, PAD, WAIT} state_t;

    localparam logic [3:0] RC_INIT = 4'(RESET_CYCLES - 1);

    state_t      state, state_d;
    logic [3:0]  rst_cnt;
    logic [1:0]  cnt;
    logic [31:0] word_q, word_nxt;
    logic        pad_q;
    logic        accept, xfer, word_end;

    // 8*(3-cnt) shift: lane 0 lands in [31:24]
    assign word_nxt   = word_q | ({24'd0, s_data} << {~cnt, 3'b000});
    assign word_end   = (cnt == 2'd3) || s_last;
    assign core_reset = reset || (state == CLR);
    assign busy       = (state != IDLE);

    always_comb begin
        state_d       = state;
        s_ready       = 1'b0;
        core_in_ready = 1'b0;
        msg_done      = 1'b0;
        accept        = 1'b0;
        xfer          = 1'b0;
        case (state)
            IDLE: if (s_valid) state_d = CLR;
            CLR:  if (rst_cnt == 4'd0) state_d = FILL;
            FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid && word_end) state_d = SEND;
            end
            SEND: begin
                core_in_ready = 1'b1;
                xfer          = !core_buffer_full;
                if (xfer) state_d = core_is_last ? WAIT : (pad_q ? PAD : FILL);
            end
            PAD: begin
                core_in_ready = 1'b1;
                xfer          = !core_buffer_full;
                if (xfer) state_d = WAIT;
            end
            WAIT: if (core_out_ready) begin
                msg_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rst_cnt       <= 4'd0;
            cnt           <= 2'd0;
            word_q        <= 32'd0;
            pad_q         <= 1'b0;
            core_in       <= 32'd0;
            core_is_last  <= 1'b0;
            core_byte_num <= 2'd0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: rst_cnt <= RC_INIT;
                CLR: begin
                    rst_cnt <= rst_cnt - 4'd1;
                    cnt     <= 2'd0;
                    word_q  <= 32'd0;
                end
                FILL: if (accept) begin
                    if (word_end) begin
                        // A short last word carries its byte count; a full last word defers is_last to PAD
                        core_in       <= word_nxt;
                        core_is_last  <= s_last && (cnt != 2'd3);
                        core_byte_num <= (s_last && (cnt != 2'd3)) ? cnt + 2'd1 : 2'd0;
                        pad_q         <= s_last && (cnt == 2'd3);
                        cnt           <= 2'd0;
                        word_q        <= 32'd0;
                    end else begin
                        word_q <= word_nxt;
                        cnt    <= cnt + 2'd1;
                    end
                end
                SEND: if (xfer && pad_q) begin
                    core_in       <= 32'd0;
                    core_is_last  <= 1'b1;
                    core_byte_num <= 2'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef KECCAK_MSG_PACKER_LEN_EN
    always_ff @(posedge clk) begin
        if (reset || state == CLR) msg_len <= 32'd0;
        else if (accept)           msg_len <= msg_len + 32'd1;
    end
`endif

endmodule

// File: tb/tb_keccak_msg_packer.sv
// Self-checking bench for keccak_msg_packer: byte-stream model of expected words plus literal pins.
module tb_keccak_msg_packer;

    localparam int RC = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bn;
        bit          done;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic        core_reset, core_in_ready, core_is_last, busy, msg_done;
    logic [31:0] core_in;
    logic [1:0]  core_byte_num;
    logic        core_buffer_full = 1'b0, core_out_ready;
    logic [1:0]  ord_dly;

    logic [7:0]  s1_data = 8'd0;
    logic        s1_valid = 1'b0, s1_last = 1'b0, s1_ready;
    logic        c1_reset, c1_in_ready, c1_is_last, busy1, done1;
    logic [31:0] c1_in;
    logic [1:0]  c1_bn;
    logic        c1_or = 1'b0;
`ifdef KECCAK_MSG_PACKER_LEN_EN
    logic [31:0] msg_len, msg_len1;
`endif

    int   checks = 0, failures = 0;
    int   rst_run = 0, xfer_cnt = 0, stall_cnt = 0, done_cnt = 0, msgs = 0;
    bit   clr_ok = 0;
    exp_t exp_q[$];
    exp_t log_q[$];

    always #5 clk = ~clk;

    keccak_msg_packer #(.RESET_CYCLES(RC)) u_dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .core_reset(core_reset), .core_in(core_in),
        .core_in_ready(core_in_ready), .core_is_last(core_is_last),
        .core_byte_num(core_byte_num), .core_buffer_full(core_buffer_full),
        .core_out_ready(core_out_ready), .busy(busy),
`ifdef KECCAK_MSG_PACKER_LEN_EN
        .msg_len(msg_len),
`endif
        .msg_done(msg_done));

    keccak_msg_packer #(.RESET_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last),
        .s_ready(s1_ready), .core_reset(c1_reset), .core_in(c1_in),
        .core_in_ready(c1_in_ready), .core_is_last(c1_is_last),
        .core_byte_num(c1_bn), .core_buffer_full(1'b0),
        .core_out_ready(c1_or), .busy(busy1),
`ifdef KECCAK_MSG_PACKER_LEN_EN
        .msg_len(msg_len1),
`endif
        .msg_done(done1));

    // Minimal core: digest becomes ready a few cycles after the last word, cleared by core reset
    always @(posedge clk) begin
        if (core_reset) begin
            core_out_ready <= 1'b0;
            ord_dly        <= 2'd0;
        end else if (core_in_ready && !core_buffer_full && core_is_last) begin
            ord_dly <= 2'd3;
        end else if (ord_dly != 2'd0) begin
            ord_dly <= ord_dly - 2'd1;
            if (ord_dly == 2'd1) core_out_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic l, input logic [1:0] b, input bit dn);
        exp_t e;
        e.data = d; e.last = l; e.bn = b; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Expected word sequence of a complete message, straight from the byte count
    task automatic build_exp(input bq_t m);
        int n, k;
        logic [31:0] w;
        n = m.size();
        for (int i = 0; i < n; i += 4) begin
            k = (n - i < 4) ? n - i : 4;
            w = 32'd0;
            for (int j = 0; j < k; j++) w = w | (32'(m[i+j]) << (24 - 8*j));
            if (i + k == n && k < 4) push_exp(w, 1'b1, 2'(k), 0);
            else                     push_exp(w, 1'b0, 2'd0, 0);
        end
        if (n % 4 == 0) push_exp(32'd0, 1'b1, 2'd0, 0);
        push_exp(32'd0, 1'b0, 2'd0, 1);
    endtask

    // Called at a negedge; returns at the negedge after the final byte is taken
    task automatic send_msg(input bq_t m, input bit keep, input bit with_last);
        int t;
        bit acc;
        for (int i = 0; i < m.size(); i++) begin
            s_valid = 1'b1;
            s_data  = m[i];
            s_last  = with_last && (i == m.size() - 1);
            t = 0;
            do begin
                acc = s_ready;
                @(negedge clk);
                t++;
            end while (!acc && t < 300);
            if (!acc) begin
                failures++;
                $display("FAIL byte_accept_timeout: byte %0d never accepted", i);
                break;
            end
        end
        if (!keep) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("msg_done_reached", 32'(done_cnt >= target), 32'd1);
    endtask

    // Compare process: every cycle, a little after the falling edge
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            rst_run = 0;
            clr_ok  = 0;
        end else begin
            if (core_reset) rst_run++;
            else if (rst_run != 0) begin
                chk("core_reset_width", 32'(rst_run), 32'(RC));
                rst_run = 0;
                clr_ok  = 1;
            end
            if (s_valid && s_ready) chk("byte_after_clear", 32'(clr_ok), 32'd1);
            if (core_in_ready) begin
                chk("s_ready_low_in_send", 32'(s_ready), 32'd0);
                if (exp_q.size() == 0 || exp_q[0].done) begin
                    failures++;
                    $display("FAIL unexpected_word: got %0h, none expected", core_in);
                end else begin
                    chk("core_in", core_in, exp_q[0].data);
                    chk("core_is_last", 32'(core_is_last), 32'(exp_q[0].last));
                    chk("core_byte_num", 32'(core_byte_num), 32'(exp_q[0].bn));
                    if (!core_buffer_full) begin
                        log_q.push_back(exp_q.pop_front());
                        xfer_cnt++;
                    end else stall_cnt++;
                end
            end
            if (msg_done) begin
                if (exp_q.size() == 0 || !exp_q[0].done) begin
                    failures++;
                    $display("FAIL early_msg_done: got pulse with %0d words outstanding", exp_q.size());
                end else begin
                    checks++;
                    void'(exp_q.pop_front());
                end
                done_cnt++;
                clr_ok = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bq_t m;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_in_ready", 32'(core_in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_msg_done", 32'(msg_done), 32'd0);
        chk("rst_core_in", core_in, 32'd0);
        chk("rst_is_last", 32'(core_is_last), 32'd0);
        chk("rst_byte_num", 32'(core_byte_num), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_core_reset", 32'(core_reset), 32'd0);

        // 13 bytes, second word stalled 3 cycles by buffer_full
        m = str2q("Hello, world!");
        build_exp(m); msgs++;
        log_q.delete(); stall_cnt = 0; base = xfer_cnt;
        fork
            send_msg(m, 0, 1);
            begin
                int t;
                t = 0;
                while (xfer_cnt < base + 1 && t < 500) begin @(negedge clk); t++; end
                core_buffer_full = 1'b1;
                t = 0;
                while (!core_in_ready && t < 500) begin @(negedge clk); t++; end
                repeat (3) @(negedge clk);
                core_buffer_full = 1'b0;
            end
        join
        wait_done(msgs);
        chk("h13_count", 32'(log_q.size()), 32'd4);
        chk("h13_w0", log_q[0].data, 32'h48656C6C);
        chk("h13_w1", log_q[1].data, 32'h6F2C2077);
        chk("h13_w2", log_q[2].data, 32'h6F726C64);
        chk("h13_w3", log_q[3].data, 32'h21000000);
        chk("h13_w3_last", 32'(log_q[3].last), 32'd1);
        chk("h13_w3_bn", 32'(log_q[3].bn), 32'd1);
        chk("h13_stall", 32'(stall_cnt), 32'd3);
`ifdef KECCAK_MSG_PACKER_LEN_EN
        chk("h13_len", msg_len, 32'd13);
`endif

        // 12 bytes: needs the terminating empty word
        m = str2q("Hello, world");
        build_exp(m); msgs++; log_q.delete();
        send_msg(m, 0, 1);
        wait_done(msgs);
        chk("h12_count", 32'(log_q.size()), 32'd4);
        chk("h12_w2_last", 32'(log_q[2].last), 32'd0);
        chk("h12_pad", log_q[3].data, 32'd0);
        chk("h12_pad_last", 32'(log_q[3].last), 32'd1);
        chk("h12_pad_bn", 32'(log_q[3].bn), 32'd0);

        // Single byte
        m = str2q("a");
        build_exp(m); msgs++; log_q.delete();
        send_msg(m, 0, 1);
        wait_done(msgs);
        chk("a_count", 32'(log_q.size()), 32'd1);
        chk("a_w0", log_q[0].data, 32'h61000000);

        // Reset after 6 bytes; only the first word reaches the core
        m = str2q("ABCDEF");
        push_exp(32'h41424344, 1'b0, 2'd0, 0);
        send_msg(m, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_in_ready", 32'(core_in_ready), 32'd0);
        chk("mid_rst_core_in", core_in, 32'd0);
        chk("mid_rst_words_left", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        m = str2q("1234567890");
        build_exp(m); msgs++; log_q.delete();
        send_msg(m, 0, 1);
        wait_done(msgs);
        chk("n10_count", 32'(log_q.size()), 32'd3);
        chk("n10_w2", log_q[2].data, 32'h39300000);
        chk("n10_w2_bn", 32'(log_q[2].bn), 32'd2);
`ifdef KECCAK_MSG_PACKER_LEN_EN
        chk("n10_len", msg_len, 32'd10);
`endif

        // Back-to-back with s_valid held high across the boundary
        log_q.delete();
        m = str2q("xyz");  build_exp(m); msgs++;
        send_msg(m, 1, 1);
        m = str2q("abcd"); build_exp(m); msgs++;
        send_msg(m, 0, 1);
        wait_done(msgs);
        chk("b2b_count", 32'(log_q.size()), 32'd3);
        chk("b2b_w0", log_q[0].data, 32'h78797A00);
        chk("b2b_w0_bn", 32'(log_q[0].bn), 32'd3);
        chk("b2b_w1", log_q[1].data, 32'h61626364);
        chk("b2b_w2_last", 32'(log_q[2].last), 32'd1);

        // RESET_CYCLES=1 instance, cycle by cycle
        s1_valid = 1'b1; s1_data = 8'h61; s1_last = 1'b1;
        #2;
        chk("r1_idle_ready", 32'(s1_ready), 32'd0);
        chk("r1_idle_creset", 32'(c1_reset), 32'd0);
        @(negedge clk); #2;
        chk("r1_clr_creset", 32'(c1_reset), 32'd1);
        chk("r1_clr_ready", 32'(s1_ready), 32'd0);
        @(negedge clk); #2;
        chk("r1_fill_creset", 32'(c1_reset), 32'd0);
        chk("r1_fill_ready", 32'(s1_ready), 32'd1);
        @(negedge clk);
        s1_valid = 1'b0; s1_last = 1'b0;
        #2;
        chk("r1_send_in_ready", 32'(c1_in_ready), 32'd1);
        chk("r1_send_in", c1_in, 32'h61000000);
        chk("r1_send_last", 32'(c1_is_last), 32'd1);
        chk("r1_send_bn", 32'(c1_bn), 32'd1);
        @(negedge clk);
        c1_or = 1'b1;
        #2;
        chk("r1_wait_in_ready", 32'(c1_in_ready), 32'd0);
        chk("r1_msg_done", 32'(done1), 32'd1);
        @(negedge clk); #2;
        chk("r1_done_pulse", 32'(done1), 32'd0);
        chk("r1_idle_busy", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_msg_packer.md
Name: keccak_msg_packer

Overview:
Host-side transmitter for the keccak core's 32-bit message input interface. Takes a byte stream with valid/ready/last handshaking and produces big-endian words with in_ready/is_last/byte_num, honouring buffer_full backpressure. Pulses the core reset before each message, inserts the empty terminating word for messages whose length is a multiple of 4, and waits for out_ready before taking the next message. Sits between a byte-oriented host/DMA and the keccak instance.

Parameters:
RESET_CYCLES, 1, cycles core_reset is held high at message start (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
s_data  input  8  message byte
s_valid  input  1  s_data valid
s_last  input  1  final byte of message, qualified by s_valid
s_ready  output  1  byte accepted when s_valid && s_ready
core_reset  output  1  to keccak reset
core_in  output  32  to keccak in; first byte in [31:24]
core_in_ready  output  1  to keccak in_ready
core_is_last  output  1  to keccak is_last
core_byte_num  output  2  to keccak byte_num
core_buffer_full  input  1  from keccak buffer_full
core_out_ready  input  1  from keccak out_ready
busy  output  1  high in any state except IDLE
msg_done  output  1  one-cycle pulse when digest ready

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE; s_ready, core_in_ready, core_is_last, busy, msg_done = 0; core_in = 0; core_byte_num = 0. core_reset = reset OR (state == CLR).
- Word transfer completes on a cycle with core_in_ready && !core_buffer_full. While core_in_ready is high and not yet accepted, core_in, core_is_last and core_byte_num hold stable.
- States:
  - IDLE: s_ready=0. When s_valid=1, go to CLR. The byte is not consumed.
  - CLR: core_reset=1 for RESET_CYCLES cycles (down-counter), then FILL. Byte count = 0, word register = 0.
  - FILL: s_ready=1. Accepted byte goes to lane cnt (cnt 0 → [31:24], 3 → [7:0]); cnt++. Stop when cnt reaches 4 or s_last=1, then load the output register and go to SEND. s_ready drops the cycle after the terminating byte.
  - SEND: core_in_ready=1, s_ready=0. Lanes not written are 0.
    - Non-last full word: is_last=0, byte_num=0.
    - Last byte with n=1..3 bytes in the word: is_last=1, byte_num=n.
    - Last byte filling the word (n=4): is_last=0, byte_num=0.
    - On transfer: last with n<4 → WAIT; last with n=4 → PAD; otherwise → FILL with cnt=0.
  - PAD: core_in=0, is_last=1, byte_num=0, core_in_ready=1. On transfer → WAIT.
  - WAIT: core_in_ready=0. On core_out_ready=1: msg_done=1 for one cycle, then IDLE.
- Latency: the first word is presented to the core 4 + RESET_CYCLES + 1 cycles after s_valid in IDLE, with a byte every cycle. Throughput is one word per 5 cycles (4 fill + 1 send) without backpressure.
- core_buffer_full high in FILL/IDLE/WAIT: no effect.
- s_valid low mid-word in FILL: wait indefinitely, no timeout.
- Reset in any state: immediate IDLE. The partial word is discarded and core_reset asserts the same cycle.
- Zero-length messages are not supported. Every message carries at least one byte.

Optional Feature:
KECCAK_MSG_PACKER_LEN_EN:
- When defined: adds output msg_len [31:0], the count of bytes accepted in the current message. Cleared in CLR, incremented per accepted byte, held through WAIT and IDLE until the next CLR. Wraps at 2^32.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- "Hello, world!" (13 bytes, last on '!') → words 0x48656C6C, 0x6F2C2077, 0x6F726C64 with is_last=0, then 0x21000000 is_last=1 byte_num=1. No PAD word. msg_done after out_ready.
- "Hello, world" (12 bytes) → 3 words is_last=0, then PAD word 0x00000000 is_last=1 byte_num=0. Exactly 4 transfers.
- Single byte "a" → one word 0x61000000 is_last=1 byte_num=1. core_reset high exactly RESET_CYCLES cycles beforehand; check RESET_CYCLES=1 and 3.
- core_buffer_full high 3 cycles while the 2nd word is presented → core_in/is_last/byte_num stable; transfer the cycle buffer_full falls; s_ready=0 throughout.
- reset asserted mid-message after 6 bytes → next cycle IDLE, outputs 0, core_reset high. A following "1234567890" (10 bytes) ends 0x39300000 is_last=1 byte_num=2. With LEN_EN, msg_len=10.
- Back-to-back messages with s_valid held high → second message waits in IDLE until msg_done, then CLR. No byte accepted before CLR completes.
